// File: rtl/op2_issue_if.sv
// Shifter-operand issue channel: op2_issue (master) offers a shift request,
// the barrel shifter (slave) takes it with sh_ready.
interface op2_issue_if;
    logic        sh_valid;
    logic        sh_ready;
    logic [1:0]  sh_type;
    logic [4:0]  sh_amount;
    logic [31:0] sh_operand;
    logic        sh_cov;
    logic        sh_cov_val;
    logic        sh_err;

    modport master (
        output sh_valid, sh_type, sh_amount, sh_operand, sh_cov, sh_cov_val, sh_err,
        input  sh_ready
    );

    modport slave (
        input  sh_valid, sh_type, sh_amount, sh_operand, sh_cov, sh_cov_val, sh_err,
        output sh_ready
    );
endinterface

// File: rtl/op2_issue.sv
// Operand-2 decode/issue for data-processing instructions: reads Rm/Rs and issues a shift request.
// Define OP2_REGSHIFT_EN to support register-specified shifts; otherwise they are flagged via sh_err.
module op2_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        cflag,
    output logic        rf_re,
    output logic [3:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    op2_issue_if.master sh
);
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, RD_RM, RD_RS, ISSUE} state_t;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  amount;
        logic [31:0] operand;
        logic        cov;
        logic        cov_val;
        logic        err;
    } sh_t;

    state_t      state, state_nxt;
    sh_t         sh_q, sh_nxt;
    logic [11:0] instr_q;
    logic        unused_instr_bits;

    assign unused_instr_bits = &{1'b0, instr[31:26], instr[24:12]};

    function automatic sh_t imm_form(input logic [11:0] f, input logic c);
        sh_t r;
        r         = '0;
        r.operand = {24'd0, f[7:0]};
        if (f[11:8] != 4'd0) begin
            r.typ    = SH_ROR;
            r.amount = {f[11:8], 1'b0};
        end else begin
            r.cov     = 1'b1;
            r.cov_val = c;
        end
        return r;
    endfunction

`ifdef OP2_REGSHIFT_EN
    logic        cflag_q;
    logic [31:0] rm_q;

    // Amount 0 on the shifter means LSR/ASR #32, which covers the n==32 cases.
    function automatic sh_t reg_form(input logic [1:0] typ, input logic [7:0] n,
                                     input logic [31:0] rm, input logic c);
        sh_t r;
        r         = '0;
        r.operand = rm;
        if (n == 8'd0) begin
            r.cov     = 1'b1;
            r.cov_val = c;
        end else begin
            case (typ)
                SH_LSL: begin
                    if (n < 8'd32) begin
                        r.amount = n[4:0];
                    end else begin
                        r.operand = '0;
                        r.cov     = 1'b1;
                        r.cov_val = (n == 8'd32) && rm[0];
                    end
                end
                SH_LSR: begin
                    if (n <= 8'd32) begin
                        r.typ    = SH_LSR;
                        r.amount = n[4:0];
                    end else begin
                        r.operand = '0;
                        r.cov     = 1'b1;
                    end
                end
                SH_ASR: begin
                    r.typ    = SH_ASR;
                    r.amount = (n < 8'd32) ? n[4:0] : 5'd0;
                end
                default: begin
                    if (n[4:0] != 5'd0) begin
                        r.typ    = SH_ROR;
                        r.amount = n[4:0];
                    end else begin
                        r.cov     = 1'b1;
                        r.cov_val = rm[31];
                    end
                end
            endcase
        end
        return r;
    endfunction
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        sh_nxt    = sh_q;
        unique case (state)
            IDLE: begin
                sh_nxt = '0;
                if (in_valid) begin
                    if (instr[25]) begin
                        state_nxt = ISSUE;
                        sh_nxt    = imm_form(instr[11:0], cflag);
`ifndef OP2_REGSHIFT_EN
                    end else if (instr[4]) begin
                        state_nxt      = ISSUE;
                        sh_nxt.cov     = 1'b1;
                        sh_nxt.cov_val = cflag;
                        sh_nxt.err     = 1'b1;
`endif
                    end else begin
                        state_nxt = RD_RM;
                    end
                end
            end
            RD_RM: begin
                if (instr_q[4]) begin
                    state_nxt = RD_RS;
                end else begin
                    state_nxt      = ISSUE;
                    sh_nxt.typ     = instr_q[6:5];
                    sh_nxt.amount  = instr_q[11:7];
                    sh_nxt.operand = rf_rdata;
                end
            end
            RD_RS: begin
`ifdef OP2_REGSHIFT_EN
                state_nxt = ISSUE;
                sh_nxt    = reg_form(instr_q[6:5], rf_rdata[7:0], rm_q, cflag_q);
`else
                state_nxt = IDLE;
`endif
            end
            ISSUE: begin
                if (sh.sh_ready) begin
                    state_nxt = IDLE;
                    sh_nxt    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= IDLE;
            sh_q    <= '0;
            instr_q <= '0;
        end else begin
            state <= state_nxt;
            sh_q  <= sh_nxt;
            if (state == IDLE && in_valid) instr_q <= instr[11:0];
        end
    end

`ifdef OP2_REGSHIFT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cflag_q <= 1'b0;
            rm_q    <= '0;
        end else begin
            if (state == IDLE && in_valid) cflag_q <= cflag;
            if (state == RD_RM)            rm_q    <= rf_rdata;
        end
    end
`endif

    // rf_rdata is taken on the edge that closes each read state.
    assign in_ready      = (state == IDLE) && !reset;
    assign rf_re         = (state == RD_RM) || (state == RD_RS);
    assign rf_addr       = (state == RD_RM) ? instr_q[3:0]
                         : (state == RD_RS) ? instr_q[11:8] : 4'd0;

    assign sh.sh_valid   = (state == ISSUE);
    assign sh.sh_type    = sh_q.typ;
    assign sh.sh_amount  = sh_q.amount;
    assign sh.sh_operand = sh_q.operand;
    assign sh.sh_cov     = sh_q.cov;
    assign sh.sh_cov_val = sh_q.cov_val;
    assign sh.sh_err     = sh_q.err;
endmodule

// File: tb/tb_op2_issue.sv
// Self-checking bench for op2_issue: directed vector table, reset corner case, random vs model.
// Expectations follow the build: register shifts are modelled only with OP2_REGSHIFT_EN.
module tb_op2_issue;
    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;

    typedef struct packed {
        logic [3:0]  lat;
        logic [1:0]  nrd;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [1:0]  typ;
        logic [4:0]  amt;
        logic [31:0] op;
        logic        cov;
        logic        val;
        logic        err;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        c;
        logic [31:0] rm;
        logic [31:0] rs;
        int          hold;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        cflag;
    logic        rf_re;
    logic [3:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic [31:0] regs [16];

    int vectors     = 0;
    int miscompares = 0;

    op2_issue_if sh_bus ();

    op2_issue dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .cflag    (cflag),
        .rf_re    (rf_re),
        .rf_addr  (rf_addr),
        .rf_rdata (rf_rdata),
        .sh       (sh_bus)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf_re ? regs[rf_addr] : 32'hDEAD_BEEF;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [41:0] got_fields();
        return {sh_bus.sh_type, sh_bus.sh_amount, sh_bus.sh_operand,
                sh_bus.sh_cov, sh_bus.sh_cov_val, sh_bus.sh_err};
    endfunction

    function automatic logic [41:0] exp_fields(input exp_t e);
        return {e.typ, e.amt, e.op, e.cov, e.val, e.err};
    endfunction

    function automatic exp_t mk(input int lat, input int nrd, input logic [3:0] ra0,
                                input logic [3:0] ra1, input logic [1:0] typ, input int amt,
                                input logic [31:0] op, input logic cov, input logic val,
                                input logic err);
        exp_t e;
        e.lat = 4'(lat); e.nrd = 2'(nrd); e.ra0 = ra0; e.ra1 = ra1;
        e.typ = typ; e.amt = 5'(amt); e.op = op; e.cov = cov; e.val = val; e.err = err;
        return e;
    endfunction

    function automatic exp_t err_exp(input logic c);
        return mk(1, 0, 4'd0, 4'd0, T_LSL, 0, 32'd0, 1'b1, c, 1'b1);
    endfunction

    // Reference model: decides the request from the operand-2 rules using integer arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic c);
        exp_t        e;
        int          rot2;
        int          n;
        logic [31:0] rm;
        e = '0;
        if (ins[25]) begin
            rot2 = 2 * int'(ins[11:8]);
            e.lat = 4'd1;
            e.op  = {24'd0, ins[7:0]};
            if (rot2 != 0) begin
                e.typ = T_ROR;
                e.amt = 5'(rot2);
            end else begin
                e.cov = 1'b1;
                e.val = c;
            end
        end else if (!ins[4]) begin
            e.lat = 4'd2; e.nrd = 2'd1; e.ra0 = ins[3:0];
            e.op  = regs[ins[3:0]];
            e.typ = ins[6:5];
            e.amt = ins[11:7];
        end else begin
`ifdef OP2_REGSHIFT_EN
            rm = regs[ins[3:0]];
            n  = int'(regs[ins[11:8]][7:0]);
            e.lat = 4'd3; e.nrd = 2'd2; e.ra0 = ins[3:0]; e.ra1 = ins[11:8];
            e.op  = rm;
            if (n == 0) begin
                e.cov = 1'b1; e.val = c;
            end else if (ins[6:5] == T_LSL) begin
                if (n < 32) e.amt = 5'(n);
                else begin
                    e.op = 32'd0; e.cov = 1'b1; e.val = (n == 32) ? rm[0] : 1'b0;
                end
            end else if (ins[6:5] == T_LSR) begin
                if (n < 32) begin e.typ = T_LSR; e.amt = 5'(n); end
                else if (n == 32) e.typ = T_LSR;
                else begin e.op = 32'd0; e.cov = 1'b1; end
            end else if (ins[6:5] == T_ASR) begin
                e.typ = T_ASR;
                e.amt = (n < 32) ? 5'(n) : 5'd0;
            end else begin
                if (n % 32 != 0) begin e.typ = T_ROR; e.amt = 5'(n % 32); end
                else begin e.cov = 1'b1; e.val = rm[31]; end
            end
`else
            e = err_exp(c);
            rm = 32'd0; n = 0;
`endif
        end
        return e;
    endfunction

    task automatic garbage();
        in_valid = 1'($urandom_range(0, 1));
        instr    = $urandom;
        cflag    = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input string nm, input logic [31:0] ins, input logic c,
                       input int hold, input exp_t e);
        int lat;
        check({nm, " idle_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; instr = ins; cflag = c; sh_bus.sh_ready = 1'b0;
        @(negedge clk);
        garbage();
        lat = 1;
        while (!sh_bus.sh_valid && lat < 6) begin
            check({nm, " rf_re"}, 64'(rf_re), 64'(lat <= int'(e.nrd)));
            if (lat <= int'(e.nrd))
                check({nm, " rf_addr"}, 64'(rf_addr), 64'((lat == 1) ? e.ra0 : e.ra1));
            @(negedge clk);
            garbage();
            lat++;
        end
        check({nm, " latency"}, 64'(lat), 64'(e.lat));
        check({nm, " fields"}, 64'(got_fields()), 64'(exp_fields(e)));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            garbage();
            check({nm, " hold_fields"}, 64'({sh_bus.sh_valid, in_ready, got_fields()}),
                  64'({1'b1, 1'b0, exp_fields(e)}));
        end
        in_valid = 1'b0;
        sh_bus.sh_ready = 1'b1;
        @(negedge clk);
        sh_bus.sh_ready = 1'b0;
        check({nm, " release"}, 64'({sh_bus.sh_valid, in_ready, rf_re}), 64'({1'b0, 1'b1, 1'b0}));
    endtask

    vec_t vecs [15];

    initial begin
        logic [31:0] ins;
        logic [3:0]  rs_i;
        logic [7:0]  nb;
        exp_t        e;
        int          cls;

        vecs[0]  = '{"imm_rot12",   32'h02000CFF, 1'b0, 32'h0, 32'h0, 1,
                     mk(1, 0, 0, 0, T_ROR, 24, 32'hFF, 0, 0, 0)};
        vecs[1]  = '{"imm_rot0",    32'h020000AB, 1'b1, 32'h0, 32'h0, 0,
                     mk(1, 0, 0, 0, T_LSL, 0, 32'hAB, 1, 1, 0)};
        vecs[2]  = '{"imm_rot1",    32'h020001FF, 1'b0, 32'h0, 32'h0, 0,
                     mk(1, 0, 0, 0, T_ROR, 2, 32'hFF, 0, 0, 0)};
        vecs[3]  = '{"shimm_lsl30", 32'h01A00F02, 1'b0, 32'h3, 32'h0, 0,
                     mk(2, 1, 2, 0, T_LSL, 30, 32'h3, 0, 0, 0)};
        vecs[4]  = '{"shimm_asr0",  32'h01A00045, 1'b1, 32'h80000000, 32'h0, 1,
                     mk(2, 1, 5, 0, T_ASR, 0, 32'h80000000, 0, 0, 0)};
        vecs[5]  = '{"shimm_rrx",   32'h01A00066, 1'b0, 32'h12345678, 32'h0, 0,
                     mk(2, 1, 6, 0, T_ROR, 0, 32'h12345678, 0, 0, 0)};
        vecs[6]  = '{"reg_lsl32",   32'h01A00311, 1'b0, 32'h80000001, 32'h20, 0,
                     mk(3, 2, 1, 3, T_LSL, 0, 32'h0, 1, 1, 0)};
        vecs[7]  = '{"reg_lsl33",   32'h01A00311, 1'b0, 32'h80000001, 32'h21, 0,
                     mk(3, 2, 1, 3, T_LSL, 0, 32'h0, 1, 0, 0)};
        vecs[8]  = '{"reg_lsl5",    32'h01A00311, 1'b0, 32'h0000000F, 32'h5, 0,
                     mk(3, 2, 1, 3, T_LSL, 5, 32'hF, 0, 0, 0)};
        vecs[9]  = '{"reg_ror64",   32'h01A00371, 1'b0, 32'h80000000, 32'h40, 4,
                     mk(3, 2, 1, 3, T_LSL, 0, 32'h80000000, 1, 1, 0)};
        vecs[10] = '{"reg_lsr32",   32'h01A00331, 1'b0, 32'hF0000000, 32'h20, 0,
                     mk(3, 2, 1, 3, T_LSR, 0, 32'hF0000000, 0, 0, 0)};
        vecs[11] = '{"reg_lsr40",   32'h01A00331, 1'b0, 32'hF0000000, 32'h28, 0,
                     mk(3, 2, 1, 3, T_LSL, 0, 32'h0, 1, 0, 0)};
        vecs[12] = '{"reg_asr200",  32'h01A00351, 1'b0, 32'h80000000, 32'hC8, 0,
                     mk(3, 2, 1, 3, T_ASR, 0, 32'h80000000, 0, 0, 0)};
        vecs[13] = '{"reg_n0",      32'h01A00331, 1'b1, 32'hAAAA5555, 32'h100, 0,
                     mk(3, 2, 1, 3, T_LSL, 0, 32'hAAAA5555, 1, 1, 0)};
        vecs[14] = '{"reg_ror35",   32'h01A00371, 1'b0, 32'h1, 32'h23, 1,
                     mk(3, 2, 1, 3, T_ROR, 3, 32'h1, 0, 0, 0)};

        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        in_valid = 1'b0; instr = '0; cflag = 1'b0; sh_bus.sh_ready = 1'b0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({in_ready, rf_re, rf_addr, sh_bus.sh_valid, got_fields()}), 64'd0);
        reset = 1'b0;
        #1;
        check("reset_release_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed vectors.
        foreach (vecs[i]) begin
            e = vecs[i].e;
`ifndef OP2_REGSHIFT_EN
            if (!vecs[i].ins[25] && vecs[i].ins[4]) e = err_exp(vecs[i].c);
`endif
            regs[vecs[i].ins[11:8]] = vecs[i].rs;
            regs[vecs[i].ins[3:0]]  = vecs[i].rm;
            run(vecs[i].name, vecs[i].ins, vecs[i].c, vecs[i].hold, e);
        end

        // Reset in the middle of a register-shift transaction.
        regs[1] = 32'h80000001; regs[3] = 32'h20;
        in_valid = 1'b1; instr = 32'h01A00311; cflag = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef OP2_REGSHIFT_EN
        @(negedge clk);
        check("mid_rd_rs", 64'({rf_re, rf_addr, sh_bus.sh_valid}), 64'({1'b1, 4'd3, 1'b0}));
`else
        check("err_one_cycle", 64'({sh_bus.sh_valid, sh_bus.sh_err, rf_re}), 64'({1'b1, 1'b1, 1'b0}));
`endif
        #2 reset = 1'b1;
        #1 check("reset_async", 64'({sh_bus.sh_valid, rf_re, in_ready, got_fields()}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("reset_after_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("reset_discarded", 64'({sh_bus.sh_valid, rf_re, in_ready}), 64'({1'b0, 1'b0, 1'b1}));

        // Random instructions against the model.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            ins = $urandom;
            cls = $urandom_range(0, 2);
            ins[25] = (cls == 0);
            if (cls != 0) ins[4] = (cls == 2);
            rs_i = ins[11:8];
            case ($urandom_range(0, 7))
                0: nb = 8'd0;
                1: nb = 8'd32;
                2: nb = 8'd33;
                3: nb = 8'd64;
                4: nb = 8'($urandom_range(1, 31));
                5: nb = 8'd255;
                6: nb = 8'd96;
                default: nb = 8'($urandom);
            endcase
            regs[rs_i][7:0] = nb;
            cflag = 1'($urandom_range(0, 1));
            e = model(ins, cflag);
            run($sformatf("rand%0d", t), ins, cflag, $urandom_range(0, 2), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
